// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// PC step size, default reset vector and a PC alignment helper.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH      = 2'd1,
    WAIT_SPACE = 2'd2,
    DISCARD    = 2'd3
  } if_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Word-align a fetch target by clearing the two low address bits.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries. Flush empties the
// queue and wins over push/pop in the same cycle. DEPTH must be a power of
// two (>= 2) so the pointers wrap naturally.
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [W-1:0]               head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(1'b0));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (flush) begin
      wr_ptr_d = AW'(1'b0);
      rd_ptr_d = AW'(1'b0);
      count_d  = CW'(1'b0);
    end else begin
      do_push_s = push & ~full;
      do_pop_s  = pop & ~empty;
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Queue state registers; storage clears on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= AW'(1'b0);
      rd_ptr_q <= AW'(1'b0);
      count_q  <= CW'(1'b0);
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: issues one outstanding request at a time to
// instruction memory, queues returned words with their PC toward decode and
// handles branch redirects (flush, discard of an in-flight stale request).
// Optional feature: define IF_PERF_CNT_EN to add the fetch_count output.
module pc_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  if_state_e     state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic          ack_s, pop_s, push_s, flush_s;
  logic          q_full, q_empty;
  logic [CW-1:0] q_count, occ_after_s;
  logic [63:0]   q_head;

  assign ack_s     = req_q & imem_ack;
  assign pop_s     = ~q_empty & out_ready;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign out_valid = ~q_empty;
  assign out_pc    = q_head[63:32];
  assign out_instr = q_head[31:0];

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .W     (64)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data ({fetch_pc_q, imem_rdata}),
    .pop       (pop_s),
    .flush     (flush_s),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .head      (q_head)
  );

  // FSM next state, fetch PC and request/address for the following cycle.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    push_s      = 1'b0;
    flush_s     = 1'b0;
    occ_after_s = q_count + CW'(1'b1) - CW'(pop_s);
    if (redirect_valid) begin
      // Redirect beats everything; a stale in-flight request must still
      // be waited out, otherwise fetching restarts at the target.
      flush_s    = 1'b1;
      fetch_pc_d = align_pc(redirect_pc);
      case (state_q)
        FETCH:      state_d = ack_s ? FETCH : DISCARD;
        DISCARD:    state_d = ack_s ? FETCH : DISCARD;
        IDLE:       state_d = FETCH;
        WAIT_SPACE: state_d = FETCH;
        default:    state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FETCH;
        end
        FETCH: begin
          if (ack_s) begin
            push_s     = ~q_full;
            fetch_pc_d = fetch_pc_q + PC_INC;
            state_d    = (occ_after_s >= DEPTH_C) ? WAIT_SPACE : FETCH;
          end else begin
            state_d = FETCH;
          end
        end
        WAIT_SPACE: begin
          state_d = pop_s ? FETCH : WAIT_SPACE;
        end
        DISCARD: begin
          state_d = ack_s ? FETCH : DISCARD;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    req_d  = (state_d == FETCH) || (state_d == DISCARD);
    // While discarding, the old request address stays on the bus.
    addr_d = (state_d == DISCARD) ? addr_q : fetch_pc_d;
  end

  // FSM, fetch PC and registered memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  assign fetch_count = fetch_count_q;

  // Count every instruction that actually enters the queue.
  always_comb begin
    fetch_count_d = fetch_count_q + {31'd0, push_s};
  end

  // Performance counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a transaction-level model predicts the request
// stream and the expected decode queue; a monitor compares on every cycle.
module tb_pc_fetch_unit;
  import if_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  pc_fetch_unit #(
    .RESET_PC    (RST_PC),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] m_target;
  logic [31:0] m_stale_addr;
  logic [31:0] m_count;
  bit          m_idle;
  bit          m_stale;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_req();
    return !m_idle && (m_stale || exp_q.size() < DEPTH);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_stale ? m_stale_addr : m_target;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_target     = RST_PC;
    m_stale_addr = RST_PC;
    m_count      = 32'd0;
    m_idle       = 1'b1;
    m_stale      = 1'b0;
  endtask

  // One clock edge of the reference: fetch stream semantics, not RTL states.
  task automatic model_step();
    bit          req;
    bit          ack;
    bit          pop;
    logic [31:0] cur;
    req = m_req();
    ack = req && imem_ack;
    pop = (exp_q.size() > 0) && out_ready;
    cur = m_addr();
    if (redirect_valid) begin
      exp_q.delete();
      m_target = redirect_pc & 32'hFFFF_FFFC;
      if (m_idle) begin
        m_idle  = 1'b0;
        m_stale = 1'b0;
      end else if (ack || !req) begin
        m_stale = 1'b0;
      end else begin
        m_stale_addr = cur;
        m_stale      = 1'b1;
      end
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (ack) begin
        if (m_stale) begin
          m_stale = 1'b0;
        end else begin
          exp_q.push_back({m_target, instr_of(m_target)});
          m_target = m_target + 32'd4;
          m_count  = m_count + 32'd1;
        end
      end
    end
  endtask

  initial model_reset();

  // Reference model advances on every rising edge.
  initial forever begin
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
  end

  // Monitor: compare DUT outputs with the model on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_req()});
      if (m_req()) chk("imem_addr", imem_addr, m_addr());
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
        chk("out_pc", out_pc, exp_q[0].pc);
        chk("out_instr", out_instr, exp_q[0].instr);
      end
`ifdef IF_PERF_CNT_EN
      chk("fetch_count", fetch_count, m_count);
`endif
    end
  end

  task automatic drive(input bit ack, input bit rdy, input bit rv, input logic [31:0] rpc);
    imem_ack       = ack;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_ack       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit          a;
    bit          r;
    bit          v;
    logic [31:0] p;
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    rst_n = 1'b1;

    // Streaming with ack and ready held high
    repeat (10) drive(1'b1, 1'b1, 1'b0, 32'd0);

    // Back-pressure: queue fills, requests stop
    repeat (6) drive(1'b1, 1'b0, 1'b0, 32'd0);
    chk("bp_req_low", {31'd0, imem_req}, 32'd0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);

    // Redirect while a request at 0x8 is pending without ack
    do_reset();
    repeat (3) drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("pend_addr", imem_addr, 32'h0000_0008);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    chk("disc_addr", imem_addr, 32'h0000_0008);
    chk("disc_req", {31'd0, imem_req}, 32'd1);
    chk("disc_flush", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("disc_hold", imem_addr, 32'h0000_0008);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("disc_drop_addr", imem_addr, 32'h0000_0100);
    chk("disc_drop_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("disc_first_pc", out_pc, 32'h0000_0100);

    // Redirect to an unaligned target with ack in the same edge
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    chk("rdack_addr", imem_addr, 32'h0000_0200);
    chk("rdack_empty", {31'd0, out_valid}, 32'd0);

    // Address wrap at the top of the space
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("wrap_next_pc", out_pc, 32'h0000_0000);

    // Asynchronous reset mid-request with one entry queued
    repeat (2) drive(1'b0, 1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_addr", imem_addr, RST_PC);
`ifdef IF_PERF_CNT_EN
    chk("async_count", fetch_count, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, RST_PC);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) p = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else p = $urandom;
      drive(a, r, v, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 2, giving the instruction queue entries; legal values are powers of two, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port redirect_valid, input, 1 bit: a taken branch or jump is present this cycle.
REQ-006 SHALL have port redirect_pc, input, 32 bits: the branch or jump target.
REQ-007 SHALL have port imem_req, output, 1 bit: instruction memory request.
REQ-008 SHALL have port imem_addr, output, 32 bits: instruction memory word address.
REQ-009 SHALL have port imem_ack, input, 1 bit: request accepted; imem_rdata is valid in the same cycle.
REQ-010 SHALL have port imem_rdata, input, 32 bits: instruction word.
REQ-011 SHALL have port out_valid, output, 1 bit: the queue head is valid toward decode.
REQ-012 SHALL have port out_ready, input, 1 bit: decode accepts the queue head.
REQ-013 SHALL have port out_pc, output, 32 bits: the PC of the queue head.
REQ-014 SHALL have port out_instr, output, 32 bits: the instruction at the queue head.

Function
REQ-015 SHALL implement the FSM states IDLE, FETCH, WAIT_SPACE and DISCARD, with imem_req=1 only in FETCH or DISCARD.
REQ-016 SHALL move from IDLE to FETCH on the first clock edge after rst_n deasserts, with fetch_pc=RESET_PC.
REQ-017 SHALL hold imem_req and imem_addr stable from assertion until an edge where imem_ack=1, with at most one request outstanding.
REQ-018 SHALL, in FETCH on an edge with ack and no redirect, push {fetch_pc, imem_rdata} into the queue and set fetch_pc to fetch_pc+4, using modulo 2^32 wrap.
REQ-019 SHALL, after that push, stay in FETCH if the post-push/pop occupancy is below QUEUE_DEPTH, and otherwise go to WAIT_SPACE.
REQ-020 SHALL move from WAIT_SPACE to FETCH on an edge where a pop occurs (out_valid & out_ready).
REQ-021 SHALL pop the queue head on an edge where out_valid & out_ready; an ack and a pop in the same edge both take effect.
REQ-022 SHALL give a latency from ack edge to out_valid=1 of one cycle when the queue is empty, and sustain a throughput of 1 instruction/cycle when ack is continuously 1 and out_ready is continuously 1.
REQ-023 SHALL drive out_pc/out_instr stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on redirect_valid=1, have priority over all other events: flush the queue (out_valid=0 next cycle) and set fetch_pc={redirect_pc[31:2],2'b00}.
REQ-025 SHALL, on redirect in FETCH without ack in the same edge, go to DISCARD.
REQ-026 SHALL, on redirect in FETCH with ack in the same edge, drop the data and stay in FETCH at the new PC.
REQ-027 SHALL, on redirect in IDLE or WAIT_SPACE, go to FETCH at the new PC.
REQ-028 SHALL, in DISCARD, keep the old request until ack, drop the returned data, then go to FETCH at the latest redirect target; a redirect in DISCARD only updates the target.
REQ-029 SHALL treat an accepted out handshake in the redirect edge as consumed, with the flush applying to the remaining entries.

Reset
REQ-030 SHALL, while rst_n=0, force state=IDLE, queue empty, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0.
REQ-031 SHALL, on reset asserted mid-request, abandon the request immediately; the memory shall tolerate this.

Configuration
REQ-032 SHALL, with IF_PERF_CNT_EN defined, add output fetch_count, 32 bits, reset 0, incremented on each non-dropped push and wrapping at 2^32.
REQ-033 SHALL, without IF_PERF_CNT_EN, not have the fetch_count port and its logic, with all other behaviour identical.

Structure
REQ-034 SHALL place the FSM state enum, the PC increment constant (4) and the default RESET_PC in shared package if_pkg.
REQ-035 SHALL implement the queue as sub-module fetch_queue: a synchronous FIFO with a 64-bit entry, push, pop, flush, full, empty and count.

Verification
REQ-036 SHALL cover reset release with ack tied 1 and out_ready 1 -> out_pc sequence 0x0,0x4,0x8 on consecutive cycles and out_valid continuous.
REQ-037 SHALL cover out_ready=0 with ack always 1 -> exactly QUEUE_DEPTH pushes, WAIT_SPACE with imem_req=0, and the head held stable.
REQ-038 SHALL cover redirect to 0x100 with a request at 0x8 pending and no ack -> DISCARD, then ack at 0x8 dropped, then the next imem_addr=0x100 and the first out_pc=0x100.
REQ-039 SHALL cover redirect to 0x203 with ack in the same edge -> data dropped, next imem_addr=0x200, and queue empty.
REQ-040 SHALL cover fetch_pc=0xFFFF_FFFC acked -> next imem_addr=0x0000_0000.
REQ-041 SHALL cover rst_n pulsed low mid-request with 1 entry queued -> out_valid=0 and imem_req=0 asynchronously, restart at RESET_PC, and fetch_count=0 when IF_PERF_CNT_EN is defined.
